// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle_control FSM and the RV32I datapath.
// MC_PERF_CNT_EN adds the cycle/instret performance counter outputs.
interface multicycle_control_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        branch_taken;
  logic        mem_ready;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        ir_we;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  alu_mode;
  logic        halted;
  logic [1:0]  halt_cause;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  modport master (
    input  opcode, funct3, branch_taken, mem_ready,
    output pc_we, pc_sel, ir_we, mem_req, mem_we, addr_sel, rf_we, wb_sel,
    output alu_a_sel, alu_b_sel, alu_mode, halted, halt_cause
`ifdef MC_PERF_CNT_EN
    , output cycle_cnt, instret_cnt
`endif
  );

  modport slave (
    output opcode, funct3, branch_taken, mem_ready,
    input  pc_we, pc_sel, ir_we, mem_req, mem_we, addr_sel, rf_we, wb_sel,
    input  alu_a_sel, alu_b_sel, alu_mode, halted, halt_cause
`ifdef MC_PERF_CNT_EN
    , input cycle_cnt, instret_cnt
`endif
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style sequencer for the multi-cycle RV32I datapath (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Define MC_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TO_W           = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE   = 4'd0,
    C_ALUI    = 4'd1,
    C_LOAD    = 4'd2,
    C_STORE   = 4'd3,
    C_BRANCH  = 4'd4,
    C_LUI     = 4'd5,
    C_AUIPC   = 4'd6,
    C_JAL     = 4'd7,
    C_JALR    = 4'd8,
    C_FENCE   = 4'd9,
    C_SYSTEM  = 4'd10,
    C_ILLEGAL = 4'd11
  } cls_t;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;
  localparam logic [1:0] ALU_ADD       = 2'd0;
  localparam logic [1:0] ALU_FUNCT     = 2'd1;
  localparam logic [1:0] ALU_COMPARE   = 2'd2;

  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t          r_state;
  state_t          w_next_state;
  logic [1:0]      r_halt_cause;
  logic [1:0]      w_next_cause;
  logic [TO_W-1:0] r_to_cnt;
  cls_t            w_cls;
  logic            w_to_expire;

  logic       w_pc_we;
  logic [1:0] w_pc_sel;
  logic       w_ir_we;
  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_addr_sel;
  logic       w_rf_we;
  logic [1:0] w_wb_sel;
  logic [1:0] w_alu_a_sel;
  logic       w_alu_b_sel;
  logic [1:0] w_alu_mode;
  logic       w_halted;
  logic [1:0] w_halt_cause;

  // funct3/funct7 are consumed by the ALU itself when alu_mode selects FUNCT
  logic w_unused_funct3;
  assign w_unused_funct3 = ^bus.funct3;

  always_comb begin
    w_cls = C_ILLEGAL;
    case (bus.opcode)
      7'b0110011: w_cls = C_RTYPE;
      7'b0010011: w_cls = C_ALUI;
      7'b0000011: w_cls = C_LOAD;
      7'b0100011: w_cls = C_STORE;
      7'b1100011: w_cls = C_BRANCH;
      7'b0110111: w_cls = C_LUI;
      7'b0010111: w_cls = C_AUIPC;
      7'b1101111: w_cls = C_JAL;
      7'b1100111: w_cls = C_JALR;
      7'b0001111: w_cls = C_FENCE;
      7'b1110011: w_cls = C_SYSTEM;
      default:    w_cls = C_ILLEGAL;
    endcase
  end

  // A late mem_ready on the last allowed wait cycle still wins over the timeout
  always_comb begin
    if (TO_EN && !bus.mem_ready && (r_to_cnt == TO_LAST)) begin
      w_to_expire = 1'b1;
    end else begin
      w_to_expire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_halt_cause <= 2'd0;
      r_to_cnt     <= '0;
    end else begin
      r_state      <= w_next_state;
      r_halt_cause <= w_next_cause;
      if (w_next_state != r_state) begin
        r_to_cnt <= '0;
      end else if (((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= r_to_cnt;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cause = r_halt_cause;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready) begin
          w_next_state = S_DECODE;
        end else if (w_to_expire) begin
          w_next_state = S_HALT;
          w_next_cause = CAUSE_TIMEOUT;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        case (w_cls)
          C_SYSTEM: begin
            w_next_state = S_HALT;
            w_next_cause = CAUSE_SYSTEM;
          end
          C_ILLEGAL: begin
            w_next_state = S_HALT;
            w_next_cause = CAUSE_ILLEGAL;
          end
          default: w_next_state = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (w_cls)
          C_LOAD, C_STORE:   w_next_state = S_MEM;
          C_BRANCH, C_FENCE: w_next_state = S_FETCH;
          default:           w_next_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          w_next_state = (w_cls == C_LOAD) ? S_WB : S_FETCH;
        end else if (w_to_expire) begin
          w_next_state = S_HALT;
          w_next_cause = CAUSE_TIMEOUT;
        end else begin
          w_next_state = S_MEM;
        end
      end
      S_WB:    w_next_state = S_FETCH;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_we      = 1'b0;
    w_pc_sel     = 2'd0;
    w_ir_we      = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_addr_sel   = 1'b0;
    w_rf_we      = 1'b0;
    w_wb_sel     = 2'd0;
    w_alu_a_sel  = 2'd0;
    w_alu_b_sel  = 1'b0;
    w_alu_mode   = ALU_ADD;
    w_halted     = 1'b0;
    w_halt_cause = 2'd0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_ir_we   = bus.mem_ready;
      end
      S_DECODE: begin
      end
      S_EXEC: begin
        case (w_cls)
          C_RTYPE: w_alu_mode = ALU_FUNCT;
          C_ALUI: begin
            w_alu_b_sel = 1'b1;
            w_alu_mode  = ALU_FUNCT;
          end
          C_LOAD, C_STORE, C_JALR: w_alu_b_sel = 1'b1;
          C_AUIPC: begin
            w_alu_a_sel = 2'd1;
            w_alu_b_sel = 1'b1;
          end
          C_BRANCH: begin
            w_alu_mode = ALU_COMPARE;
            w_pc_we    = 1'b1;
            w_pc_sel   = bus.branch_taken ? 2'd1 : 2'd0;
          end
          C_FENCE: w_pc_we = 1'b1;
          default: begin
          end
        endcase
      end
      S_MEM: begin
        w_mem_req   = 1'b1;
        w_addr_sel  = 1'b1;
        w_alu_b_sel = 1'b1;
        w_mem_we    = (w_cls == C_STORE);
        w_pc_we     = (w_cls == C_STORE) && bus.mem_ready;
      end
      S_WB: begin
        w_rf_we = 1'b1;
        w_pc_we = 1'b1;
        case (w_cls)
          C_LOAD: w_wb_sel = 2'd1;
          C_JAL: begin
            w_wb_sel = 2'd2;
            w_pc_sel = 2'd1;
          end
          C_JALR: begin
            w_wb_sel    = 2'd2;
            w_pc_sel    = 2'd2;
            w_alu_b_sel = 1'b1;
          end
          C_LUI:   w_wb_sel = 2'd3;
          default: w_wb_sel = 2'd0;
        endcase
      end
      S_HALT: begin
        w_halted     = 1'b1;
        w_halt_cause = r_halt_cause;
      end
      default: begin
      end
    endcase
  end

  // Reset cycle silences every output so no partial write escapes an abort
  assign bus.pc_we      = rst_n & w_pc_we;
  assign bus.pc_sel     = rst_n ? w_pc_sel : 2'd0;
  assign bus.ir_we      = rst_n & w_ir_we;
  assign bus.mem_req    = rst_n & w_mem_req;
  assign bus.mem_we     = rst_n & w_mem_we;
  assign bus.addr_sel   = rst_n & w_addr_sel;
  assign bus.rf_we      = rst_n & w_rf_we;
  assign bus.wb_sel     = rst_n ? w_wb_sel : 2'd0;
  assign bus.alu_a_sel  = rst_n ? w_alu_a_sel : 2'd0;
  assign bus.alu_b_sel  = rst_n & w_alu_b_sel;
  assign bus.alu_mode   = rst_n ? w_alu_mode : 2'd0;
  assign bus.halted     = rst_n & w_halted;
  assign bus.halt_cause = rst_n ? w_halt_cause : 2'd0;

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  // Retired instructions are counted on their single pc_we cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle_cnt   <= 32'd0;
      r_instret_cnt <= 32'd0;
    end else begin
      if (r_state != S_HALT) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end else begin
        r_cycle_cnt <= r_cycle_cnt;
      end
      if (w_pc_we) begin
        r_instret_cnt <= r_instret_cnt + 32'd1;
      end else begin
        r_instret_cnt <= r_instret_cnt;
      end
    end
  end

  assign bus.cycle_cnt   = rst_n ? r_cycle_cnt : 32'd0;
  assign bus.instret_cnt = rst_n ? r_instret_cnt : 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one default instance and one with an 8-cycle timeout.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       ir_we;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_mode;
    logic       halted;
    logic [1:0] halt_cause;
  } ctl_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  multicycle_control_if bus0 ();
  multicycle_control_if bus1 ();

  multicycle_control dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.master)
  );

  multicycle_control #(.TIMEOUT_CYCLES(8), .TO_W(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  always #5 clk = ~clk;

  function automatic ctl_t obs0();
    ctl_t o;
    o.pc_we = bus0.pc_we;         o.pc_sel = bus0.pc_sel;
    o.ir_we = bus0.ir_we;         o.mem_req = bus0.mem_req;
    o.mem_we = bus0.mem_we;       o.addr_sel = bus0.addr_sel;
    o.rf_we = bus0.rf_we;         o.wb_sel = bus0.wb_sel;
    o.alu_a_sel = bus0.alu_a_sel; o.alu_b_sel = bus0.alu_b_sel;
    o.alu_mode = bus0.alu_mode;   o.halted = bus0.halted;
    o.halt_cause = bus0.halt_cause;
    return o;
  endfunction

  function automatic ctl_t obs1();
    ctl_t o;
    o.pc_we = bus1.pc_we;         o.pc_sel = bus1.pc_sel;
    o.ir_we = bus1.ir_we;         o.mem_req = bus1.mem_req;
    o.mem_we = bus1.mem_we;       o.addr_sel = bus1.addr_sel;
    o.rf_we = bus1.rf_we;         o.wb_sel = bus1.wb_sel;
    o.alu_a_sel = bus1.alu_a_sel; o.alu_b_sel = bus1.alu_b_sel;
    o.alu_mode = bus1.alu_mode;   o.halted = bus1.halted;
    o.halt_cause = bus1.halt_cause;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [31:0] instr);
    bus0.opcode = instr[6:0];
    bus0.funct3 = instr[14:12];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ctl_t e;
    ctl_t o;
    rst_n = 1'b0;
    load0(32'h002081B3);
    bus0.mem_ready = 1'b1;
    step();
    #2;
    e = '0;
    o = obs0();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_outputs_zero: got %h want %h", o, e); end
    o = obs1();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_outputs_zero_to: got %h want %h", o, e); end
    step();
    rst_n = 1'b1;
    bus0.mem_ready = 1'b0;
    #2;
    e = '0; e.mem_req = 1'b1;
    o = obs0();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_first_fetch: got %h want %h", o, e); end
    step();
  endtask

  task automatic test_add();
    ctl_t e;
    ctl_t o;
    ctl_t ex[$];
    load0(32'h002081B3);
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; ex.push_back(e);
    e = '0; ex.push_back(e);
    e = '0; e.alu_mode = 2'd1; ex.push_back(e);
    e = '0; e.rf_we = 1'b1; e.pc_we = 1'b1; ex.push_back(e);
    for (int i = 0; i < ex.size(); i++) begin
      bus0.mem_ready = 1'b1;
      #2;
      o = obs0();
      checks++;
      if (o !== ex[i]) begin errors++; $display("FAIL add cyc%0d: got %h want %h", i, o, ex[i]); end
      step();
    end
  endtask

  task automatic test_lw();
    ctl_t e;
    ctl_t o;
    ctl_t ex[$];
    logic mr[$];
    load0(32'h0000A103);
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; ex.push_back(e); mr.push_back(1'b1);
    e = '0; ex.push_back(e); mr.push_back(1'b1);
    e = '0; e.alu_b_sel = 1'b1; ex.push_back(e); mr.push_back(1'b1);
    for (int k = 0; k < 4; k++) begin
      e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.alu_b_sel = 1'b1;
      ex.push_back(e);
      mr.push_back(k == 3);
    end
    e = '0; e.rf_we = 1'b1; e.pc_we = 1'b1; e.wb_sel = 2'd1; ex.push_back(e); mr.push_back(1'b1);
    for (int i = 0; i < ex.size(); i++) begin
      bus0.mem_ready = mr[i];
      #2;
      o = obs0();
      checks++;
      if (o !== ex[i]) begin errors++; $display("FAIL lw cyc%0d: got %h want %h", i, o, ex[i]); end
      step();
    end
  endtask

  task automatic test_store();
    ctl_t e;
    ctl_t o;
    ctl_t ex[$];
    load0(32'h0020A023);
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; ex.push_back(e);
    e = '0; ex.push_back(e);
    e = '0; e.alu_b_sel = 1'b1; ex.push_back(e);
    e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.alu_b_sel = 1'b1; e.mem_we = 1'b1;
    e.pc_we = 1'b1; ex.push_back(e);
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; ex.push_back(e);
    for (int i = 0; i < ex.size(); i++) begin
      bus0.mem_ready = 1'b1;
      #2;
      o = obs0();
      checks++;
      if (o !== ex[i]) begin errors++; $display("FAIL sw cyc%0d: got %h want %h", i, o, ex[i]); end
      if (i < ex.size() - 1) step();
    end
  endtask

  task automatic test_branch();
    ctl_t e;
    ctl_t o;
    ctl_t ex[$];
    load0(32'h00208463);
    for (int bt = 1; bt >= 0; bt--) begin
      ex.delete();
      bus0.branch_taken = (bt == 1);
      e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; ex.push_back(e);
      e = '0; ex.push_back(e);
      e = '0; e.alu_mode = 2'd2; e.pc_we = 1'b1; e.pc_sel = (bt == 1) ? 2'd1 : 2'd0; ex.push_back(e);
      for (int i = 0; i < ex.size(); i++) begin
        bus0.mem_ready = 1'b1;
        #2;
        o = obs0();
        checks++;
        if (o !== ex[i]) begin
          errors++;
          $display("FAIL beq_bt%0d cyc%0d: got %h want %h", bt, i, o, ex[i]);
        end
        step();
      end
    end
    bus0.branch_taken = 1'b0;
  endtask

  task automatic test_jalr_illegal();
    ctl_t e;
    ctl_t o;
    ctl_t ex[$];
    logic [31:0] iw[$];
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; ex.push_back(e); iw.push_back(32'h000080E7);
    e = '0; ex.push_back(e); iw.push_back(32'h000080E7);
    e = '0; e.alu_b_sel = 1'b1; ex.push_back(e); iw.push_back(32'h000080E7);
    e = '0; e.rf_we = 1'b1; e.pc_we = 1'b1; e.wb_sel = 2'd2; e.pc_sel = 2'd2; e.alu_b_sel = 1'b1;
    ex.push_back(e); iw.push_back(32'h000080E7);
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; ex.push_back(e); iw.push_back(32'h0000007F);
    e = '0; ex.push_back(e); iw.push_back(32'h0000007F);
    for (int k = 0; k < 4; k++) begin
      e = '0; e.halted = 1'b1; e.halt_cause = 2'd1; ex.push_back(e); iw.push_back(32'h0000007F);
    end
    for (int i = 0; i < ex.size(); i++) begin
      load0(iw[i]);
      bus0.mem_ready = (i < 6) ? 1'b1 : i[0];
      #2;
      o = obs0();
      checks++;
      if (o !== ex[i]) begin errors++; $display("FAIL jalr_ill cyc%0d: got %h want %h", i, o, ex[i]); end
      step();
    end
  endtask

  task automatic test_system();
    ctl_t e;
    ctl_t o;
    ctl_t ex[$];
    do_reset();
    load0(32'h00000073);
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; ex.push_back(e);
    e = '0; ex.push_back(e);
    e = '0; e.halted = 1'b1; e.halt_cause = 2'd2; ex.push_back(e);
    ex.push_back(e);
    for (int i = 0; i < ex.size(); i++) begin
      bus0.mem_ready = 1'b1;
      #2;
      o = obs0();
      checks++;
      if (o !== ex[i]) begin errors++; $display("FAIL ecall cyc%0d: got %h want %h", i, o, ex[i]); end
      step();
    end
  endtask

  task automatic test_no_timeout_default();
    ctl_t e;
    ctl_t o;
    do_reset();
    load0(32'h002081B3);
    bus0.mem_ready = 1'b0;
    e = '0; e.mem_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #2;
      o = obs0();
      checks++;
      if (o !== e) begin errors++; $display("FAIL no_timeout cyc%0d: got %h want %h", i, o, e); end
      step();
    end
  endtask

  task automatic test_timeout();
    ctl_t e;
    ctl_t o;
    bus1.opcode = 7'b0110011;
    bus1.funct3 = 3'd0;
    for (int run = 0; run < 2; run++) begin
      bus1.mem_ready = 1'b0;
      do_reset();
      for (int i = 1; i <= 9; i++) begin
        bus1.mem_ready = (run == 1) && (i == 8);
        e = '0;
        if (i <= 8) begin
          e.mem_req = 1'b1;
          e.ir_we = (run == 1) && (i == 8);
        end else if (run == 0) begin
          e.halted = 1'b1;
          e.halt_cause = 2'd3;
        end
        #2;
        o = obs1();
        checks++;
        if (o !== e) begin errors++; $display("FAIL timeout_run%0d cyc%0d: got %h want %h", run, i, o, e); end
        step();
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    ctl_t e;
    ctl_t o;
    do_reset();
    load0(32'h0020A023);
    bus0.mem_ready = 1'b1;
    step();
    step();
    step();
    bus0.mem_ready = 1'b0;
    #2;
    e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.alu_b_sel = 1'b1; e.mem_we = 1'b1;
    o = obs0();
    checks++;
    if (o !== e) begin errors++; $display("FAIL mid_mem_before: got %h want %h", o, e); end
    step();
    rst_n = 1'b0;
    #2;
    e = '0;
    o = obs0();
    checks++;
    if (o !== e) begin errors++; $display("FAIL mid_mem_reset_cycle: got %h want %h", o, e); end
    step();
    rst_n = 1'b1;
    #2;
    e = '0; e.mem_req = 1'b1;
    o = obs0();
    checks++;
    if (o !== e) begin errors++; $display("FAIL mid_mem_refetch: got %h want %h", o, e); end
`ifdef MC_PERF_CNT_EN
    checks++;
    if (bus0.cycle_cnt !== 32'd0) begin
      errors++; $display("FAIL mid_mem_cycle_cnt: got %0d want 0", bus0.cycle_cnt);
    end
    checks++;
    if (bus0.instret_cnt !== 32'd0) begin
      errors++; $display("FAIL mid_mem_instret_cnt: got %0d want 0", bus0.instret_cnt);
    end
`endif
    step();
  endtask

`ifdef MC_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    load0(32'h002081B3);
    bus0.mem_ready = 1'b1;
    repeat (12) step();
    #2;
    checks++;
    if (bus0.instret_cnt !== 32'd3) begin
      errors++; $display("FAIL perf_instret: got %0d want 3", bus0.instret_cnt);
    end
    checks++;
    if (bus0.cycle_cnt !== 32'd12) begin
      errors++; $display("FAIL perf_cycle: got %0d want 12", bus0.cycle_cnt);
    end
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    checks = 0;
    errors = 0;
    bus0.opcode = 7'd0; bus0.funct3 = 3'd0; bus0.branch_taken = 1'b0; bus0.mem_ready = 1'b0;
    bus1.opcode = 7'd0; bus1.funct3 = 3'd0; bus1.branch_taken = 1'b0; bus1.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw();
    test_store();
    test_branch();
    test_jalr_illegal();
    test_system();
    test_no_timeout_default();
    test_timeout();
    test_reset_mid_mem();
`ifdef MC_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the multi-cycle RV32I datapath: fetch, decode, execute, memory, writeback.
- Consumes the opcode, funct3 and funct7 fields produced by the instruction decoder, plus datapath status (branch_taken, mem_ready).
- Drives the datapath enables and mux selects (PC, IR, register file, ALU operands, memory request).
- Sits between the decoder and the PC/IR/regfile/ALU/memory-port datapath.

Parameters:
- TIMEOUT_CYCLES, 0, maximum cycles to wait for mem_ready in FETCH/MEM before halting; 0 disables the timeout.
- TO_W, 16, width of the timeout counter; TIMEOUT_CYCLES must be < 2**TO_W.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- opcode  in  7  instruction[6:0] from decoder (IR-registered)
- funct3  in  3  decoder funct3
- branch_taken  in  1  datapath comparator result, valid in EXEC
- mem_ready  in  1  memory port accepts/completes the current request this cycle
- pc_we  out  1  load PC
- pc_sel  out  2  0=PC+4, 1=PC+imm (branch/JAL), 2=ALU result & ~1 (JALR)
- ir_we  out  1  load IR from memory read data
- mem_req  out  1  memory request valid
- mem_we  out  1  store (valid with mem_req)
- addr_sel  out  1  0=PC (fetch), 1=ALU result (data access)
- rf_we  out  1  register-file write
- wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4, 3=imm
- alu_a_sel  out  2  0=rs1, 1=PC, 2=zero
- alu_b_sel  out  1  0=rs2, 1=imm
- alu_mode  out  2  0=ADD, 1=FUNCT (use funct3/funct7), 2=COMPARE
- halted  out  1  FSM in HALT
- halt_cause  out  2  0=none, 1=illegal opcode, 2=SYSTEM (ECALL/EBREAK), 3=memory timeout

Behaviour:
- Reset: while rst_n=0 at a rising edge, state<=FETCH, halt_cause<=0, timeout counter<=0.
- All outputs are combinational from the state register and opcode, and are forced to 0 during any cycle in which rst_n=0.
- The first request after reset (mem_req=1, addr_sel=0) is asserted in the cycle after rst_n rises.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. Hold until mem_ready=1; that cycle ir_we=1 and next state is DECODE.
- DECODE: single cycle, no enables asserted. Opcode routing:
  - Legal opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111, 0001111 -> EXEC.
  - 1110011 -> HALT with cause 2.
  - Any other opcode -> HALT with cause 1.
- EXEC (single cycle), per instruction class:
  - R-type: a=rs1, b=rs2, mode=FUNCT -> WB.
  - ALU-imm: a=rs1, b=imm, mode=FUNCT -> WB.
  - Load/store: a=rs1, b=imm, mode=ADD -> MEM.
  - Branch: a=rs1, b=rs2, mode=COMPARE; pc_we=1, pc_sel = branch_taken ? 1 : 0 -> FETCH.
  - LUI: -> WB.
  - AUIPC: a=PC, b=imm, mode=ADD -> WB.
  - JAL: -> WB.
  - JALR: a=rs1, b=imm, mode=ADD -> WB.
  - FENCE: NOP; pc_we=1, pc_sel=0 -> FETCH.
- MEM: mem_req=1, addr_sel=1, alu operands held as in EXEC, mem_we=1 for stores. Hold until mem_ready=1, then:
  - Load -> WB.
  - Store: pc_we=1, pc_sel=0 -> FETCH.
- WB: rf_we=1 and pc_we=1 in the same cycle, then -> FETCH. Per class:
  - ALU/AUIPC: wb_sel=0.
  - Load: wb_sel=1.
  - JAL: wb_sel=2, pc_sel=1.
  - JALR: wb_sel=2, pc_sel=2; ALU operands held as in EXEC.
  - LUI: wb_sel=3.
  - All others: pc_sel=0.
- HALT: all enables 0, halted=1, halt_cause held. Sticky; only reset exits.
- Latencies with zero-wait memory (mem_ready=1 on first request cycle): R/I-ALU 4 cycles, load 5, store 4, branch 3.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter increments each FETCH/MEM cycle with mem_ready=0 and clears on state change.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0 -> HALT with cause 3.
  - mem_ready=1 in the same cycle the count would expire wins: normal transition, no halt.
- Reset asserted mid-instruction (any state, including a MEM cycle with mem_req=1) aborts immediately. No partial pc_we or rf_we occurs in the reset cycle.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt (out, 32) and instret_cnt (out, 32), both reset to 0.
  - cycle_cnt increments every cycle while not in HALT.
  - instret_cnt increments on every cycle with pc_we=1.
  - Both wrap modulo 2^32.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then ADD (0x002081B3), mem_ready tied 1 -> states FETCH, DECODE, EXEC, WB; rf_we=1 and wb_sel=0 in cycle 4 only; pc_we once.
- LW (0x0000A103), mem_ready low 3 cycles in MEM -> MEM held 4 cycles with mem_req=1, addr_sel=1, mem_we=0; then WB with wb_sel=1.
- BEQ (0x00208463): branch_taken=1 -> pc_we=1, pc_sel=1 in EXEC and rf_we never asserted; repeat with branch_taken=0 -> pc_sel=0.
- JALR (0x000080E7) -> EXEC then WB with rf_we=1, wb_sel=2, pc_sel=2; followed by illegal opcode 0x0000007F -> halted=1, halt_cause=1, no enables thereafter.
- TIMEOUT_CYCLES=8, mem_ready held 0 in FETCH -> HALT with halt_cause=3 after 8 waiting cycles; a second run with mem_ready=1 on the 8th cycle -> DECODE, no halt.
- With MC_PERF_CNT_EN: three ADDs at zero-wait memory -> instret_cnt=3, cycle_cnt=12; rst_n low one cycle mid-MEM of a store -> both counters 0, no mem_we in the reset cycle.
